// File: rtl/sd_pkg.sv
// sd_pkg: shared types for the Soundrive sample scheduler.
// Channel ids, FIFO entry layout and scheduler FSM states.
package sd_pkg;

  typedef enum logic [1:0] {
    CH_L0 = 2'd0,
    CH_L1 = 2'd1,
    CH_R0 = 2'd2,
    CH_R1 = 2'd3
  } sd_ch_t;

  typedef struct packed {
    sd_ch_t     ch;
    logic [7:0] data;
  } sd_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } sd_state_t;

  localparam int SD_FRAME = 4;

endpackage

// File: rtl/sd_fifo.sv
// sd_fifo: synchronous FIFO of sd_entry_t with flush.
// Combinational read of the head entry; caller guards push/pop.
module sd_fifo
  import sd_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  sd_entry_t              din,
  output sd_entry_t              dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  sd_entry_t      mem [DEPTH];
  logic [AW-1:0]  wp;
  logic [AW-1:0]  rp;

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign dout  = mem[rp];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/sd_sched.sv
// sd_sched: Soundrive sample scheduler, direct or FIFO-paced.
// Define SD_RATE_PROG_EN for a programmable sample-tick period.
module sd_sched
  import sd_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int DIV       = 640,
  parameter int RATE_UNIT = 32
) (
  input  logic                   clk28,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   buf_mode,
  input  logic                   wr,
  input  logic [1:0]             wr_ch,
  input  logic [7:0]             wr_data,
  input  logic                   status_rd,
  input  logic                   rate_wr,
  input  logic [7:0]             rate_data,
  output logic [7:0]             sd_l0,
  output logic [7:0]             sd_l1,
  output logic [7:0]             sd_r0,
  output logic [7:0]             sd_r1,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic                   overflow
);

  localparam int CW = 16;
  localparam int LW = $clog2(DEPTH) + 1;

  logic          active;
  logic          tick;
  logic          pop;
  logic          push_ok;
  logic          drop;
  logic          last;
  logic          rate_clr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] period;
  sd_state_t     state;
  sd_state_t     state_n;
  logic [1:0]    n;
  logic [1:0]    n_n;
  logic          pend;
  logic          pend_n;
  sd_entry_t     din;
  sd_entry_t     dout;
  logic [7:0]    ch_reg [4];

  assign active = en & buf_mode;

`ifdef SD_RATE_PROG_EN
  logic [7:0] rate;

  // programmable rate register
  always_ff @(posedge clk28) begin
    if (!rst_n)       rate <= 8'(DIV / RATE_UNIT - 1);
    else if (rate_wr) rate <= rate_data;
  end

  assign period   = (CW'(rate) + CW'(1)) * CW'(RATE_UNIT);
  assign rate_clr = rate_wr;
`else
  logic unused_rate;
  assign unused_rate = ^{rate_wr, rate_data, 32'(RATE_UNIT)};
  assign period      = CW'(DIV);
  assign rate_clr    = 1'b0;
`endif

  // free-running sample-tick counter
  always_ff @(posedge clk28) begin
    if (!rst_n)        cnt <= '0;
    else if (rate_clr) cnt <= '0;
    else if (tick)     cnt <= '0;
    else               cnt <= cnt + CW'(1);
  end

  assign tick    = (cnt == period - CW'(1));
  assign din     = '{ch: sd_ch_t'(wr_ch), data: wr_data};
  assign push_ok = active & wr & (~fifo_full | pop);
  assign drop    = active & wr & fifo_full & ~pop;
  assign last    = (fifo_level == LW'(1)) & ~push_ok;

  sd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk28),
    .rst_n (rst_n),
    .push  (push_ok),
    .pop   (pop),
    .flush (~active),
    .din   (din),
    .dout  (dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // FSM state, burst count and pending tick
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      state <= IDLE;
      n     <= '0;
      pend  <= 1'b0;
    end else begin
      state <= state_n;
      n     <= n_n;
      pend  <= pend_n;
    end
  end

  // next state: drain up to one frame per tick
  always_comb begin
    state_n = state;
    n_n     = n;
    pend_n  = pend;
    if (!active) begin
      state_n = IDLE;
      n_n     = '0;
      pend_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (tick && !fifo_empty) begin
            state_n = DRAIN;
            n_n     = '0;
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            state_n = IDLE;
            n_n     = '0;
            pend_n  = 1'b0;
          end else if (n == 2'(SD_FRAME - 1) || last) begin
            n_n     = '0;
            pend_n  = 1'b0;
            state_n = ((pend | tick) & ~last) ? DRAIN : IDLE;
          end else begin
            n_n    = n + 2'd1;
            pend_n = pend | tick;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // outputs: one pop per DRAIN cycle
  always_comb begin
    pop = 1'b0;
    if (active && state == DRAIN && !fifo_empty) pop = 1'b1;
  end

  // sticky overflow, set beats clear
  always_ff @(posedge clk28) begin
    if (!rst_n)         overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (status_rd) overflow <= 1'b0;
  end

  // channel registers from FIFO or direct writes
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) ch_reg[i] <= 8'h00;
    end else if (pop) begin
      ch_reg[dout.ch] <= dout.data;
    end else if (en && !buf_mode && wr) begin
      ch_reg[wr_ch] <= wr_data;
    end
  end

  assign sd_l0 = ch_reg[0];
  assign sd_l1 = ch_reg[1];
  assign sd_r0 = ch_reg[2];
  assign sd_r1 = ch_reg[3];

endmodule

// File: tb/tb_sd_sched.sv
// tb_sd_sched: randomized + directed checks against a queue model.
// Instance a uses DIV=640; instance b uses DIV=3 to hit mid-drain ticks.
module tb_sd_sched;

  localparam int DEPTH = 16;
`ifdef SD_RATE_PROG_EN
  localparam int EXP_P = 128;
`else
  localparam int EXP_P = 640;
`endif

  logic       clk28 = 1'b0;
  logic       rst_n, en, buf_mode, wr, status_rd, rate_wr;
  logic [1:0] wr_ch;
  logic [7:0] wr_data, rate_data;

  logic [7:0] a_l0, a_l1, a_r0, a_r1, b_l0, b_l1, b_r0, b_r1;
  logic [4:0] a_lvl, b_lvl;
  logic       a_full, a_empty, a_ovf, b_full, b_empty, b_ovf;
  logic [39:0] obs0, obs1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int mq [2][$];
  int mreg [2][4];
  bit movf [2];
  int mcnt [2];
  int mper [2];
  bit mbusy [2];
  int mpop [2];
  bit mpend [2];
  int div_of [2] = '{640, 3};
  int unit_of [2] = '{32, 1};

  always #5 clk28 = ~clk28;

  sd_sched u_a (
    .clk28(clk28), .rst_n(rst_n), .en(en), .buf_mode(buf_mode),
    .wr(wr), .wr_ch(wr_ch), .wr_data(wr_data),
    .status_rd(status_rd), .rate_wr(rate_wr), .rate_data(rate_data),
    .sd_l0(a_l0), .sd_l1(a_l1), .sd_r0(a_r0), .sd_r1(a_r1),
    .fifo_level(a_lvl), .fifo_full(a_full), .fifo_empty(a_empty),
    .overflow(a_ovf)
  );

  sd_sched #(.DEPTH(16), .DIV(3), .RATE_UNIT(1)) u_b (
    .clk28(clk28), .rst_n(rst_n), .en(en), .buf_mode(buf_mode),
    .wr(wr), .wr_ch(wr_ch), .wr_data(wr_data),
    .status_rd(status_rd), .rate_wr(rate_wr), .rate_data(rate_data),
    .sd_l0(b_l0), .sd_l1(b_l1), .sd_r0(b_r0), .sd_r1(b_r1),
    .fifo_level(b_lvl), .fifo_full(b_full), .fifo_empty(b_empty),
    .overflow(b_ovf)
  );

  assign obs0 = {a_l0, a_l1, a_r0, a_r1, a_lvl, a_full, a_empty, a_ovf};
  assign obs1 = {b_l0, b_l1, b_r0, b_r1, b_lvl, b_full, b_empty, b_ovf};

  // queue-level model of one scheduler, advanced by one clock
  task automatic model_step(int k);
    bit act, tick, pop, acc;
    int sz0, head;
    if (!rst_n) begin
      mq[k].delete();
      for (int i = 0; i < 4; i++) mreg[k][i] = 0;
      movf[k] = 0; mcnt[k] = 0; mper[k] = div_of[k];
      mbusy[k] = 0; mpop[k] = 0; mpend[k] = 0;
      return;
    end
    act  = en && buf_mode;
    sz0  = mq[k].size();
    tick = (mcnt[k] == mper[k] - 1);
    pop  = act && mbusy[k] && sz0 > 0;
    acc  = (sz0 < DEPTH) || pop;
    if (act && wr && !acc) movf[k] = 1;
    else if (status_rd)    movf[k] = 0;
    if (pop) begin
      head = mq[k].pop_front();
      mreg[k][head >> 8] = head & 255;
    end else if (en && !buf_mode && wr) begin
      mreg[k][wr_ch] = int'(wr_data);
    end
    if (act && wr && acc) mq[k].push_back(int'(wr_ch) * 256 + int'(wr_data));
    if (!act) begin
      mq[k].delete();
      mbusy[k] = 0; mpop[k] = 0; mpend[k] = 0;
    end else if (!mbusy[k]) begin
      if (tick && sz0 > 0) begin mbusy[k] = 1; mpop[k] = 0; end
    end else begin
      mpop[k]++;
      if (mpop[k] == 4 || mq[k].size() == 0) begin
        mbusy[k] = (mpend[k] || tick) && mq[k].size() > 0;
        mpop[k] = 0; mpend[k] = 0;
      end else begin
        mpend[k] = mpend[k] | tick;
      end
    end
`ifdef SD_RATE_PROG_EN
    if (rate_wr) begin
      mper[k] = (int'(rate_data) + 1) * unit_of[k];
      mcnt[k] = 0;
    end else begin
      mcnt[k] = tick ? 0 : mcnt[k] + 1;
    end
`else
    mcnt[k] = tick ? 0 : mcnt[k] + 1;
`endif
  endtask

  function automatic logic [39:0] mexp(int k);
    int lv;
    lv = mq[k].size();
    return {8'(mreg[k][0]), 8'(mreg[k][1]), 8'(mreg[k][2]), 8'(mreg[k][3]),
            5'(lv), (lv == DEPTH), (lv == 0), movf[k]};
  endfunction

  task automatic step();
    model_step(0);
    model_step(1);
    @(posedge clk28);
    #1;
    cyc++;
  endtask

  task automatic do_push(int ch, int d);
    wr = 1'b1; wr_ch = 2'(ch); wr_data = 8'(d);
    step();
    wr = 1'b0;
  endtask

  task automatic flush_buf();
    buf_mode = 1'b0; step(); buf_mode = 1'b1;
  endtask

  task automatic align_tick();
    for (int i = 0; i < 1000; i++) begin
      if (mcnt[0] == 5) break;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; buf_mode = 1'b0; wr = 1'b0;
    wr_ch = '0; wr_data = '0; status_rd = 1'b0;
    rate_wr = 1'b0; rate_data = '0;
    step(); step();
    n_tests++;
    if (obs0 !== 40'h2) begin
      n_fail++; $display("FAIL reset_a got=%h exp=%h", obs0, 40'h2);
    end
    n_tests++;
    if (obs1 !== 40'h2) begin
      n_fail++; $display("FAIL reset_b got=%h exp=%h", obs1, 40'h2);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_direct();
    en = 1'b1; buf_mode = 1'b0;
    do_push(2, 8'hA5);
    n_tests++;
    if ({a_l0, a_l1, a_r0, a_r1} !== 32'h0000A500) begin
      n_fail++;
      $display("FAIL direct_r0 got=%h exp=%h", {a_l0, a_l1, a_r0, a_r1},
               32'h0000A500);
    end
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      wr_ch = 2'($urandom); wr_data = 8'($urandom);
      step();
      n_tests++;
      if (obs0 !== mexp(0)) begin
        n_fail++; $display("FAIL direct_rand got=%h exp=%h", obs0, mexp(0));
      end
    end
    wr = 1'b0;
  endtask

  task automatic test_buffered_frame();
    bit ok;
    buf_mode = 1'b1;
    flush_buf();
    align_tick();
    do_push(0, 8'h11); do_push(1, 8'h22);
    do_push(2, 8'h33); do_push(3, 8'h44);
    n_tests++;
    if (a_lvl !== 5'd4 || obs0 !== mexp(0)) begin
      n_fail++; $display("FAIL frame_queued got=%h exp=%h", obs0, mexp(0));
    end
    ok = 0;
    for (int i = 0; i < 700; i++) begin
      step();
      n_tests++;
      if (obs0 !== mexp(0)) begin
        n_fail++; $display("FAIL frame_wait got=%h exp=%h", obs0, mexp(0));
      end
      if (a_lvl == 5'd3) begin ok = 1; break; end
    end
    n_tests++;
    if (!ok || a_l0 !== 8'h11) begin
      n_fail++; $display("FAIL frame_l0 got=%h exp=11 ok=%0d", a_l0, ok);
    end
    step();
    n_tests++;
    if (a_l1 !== 8'h22) begin
      n_fail++; $display("FAIL frame_l1 got=%h exp=22", a_l1);
    end
    step();
    n_tests++;
    if (a_r0 !== 8'h33) begin
      n_fail++; $display("FAIL frame_r0 got=%h exp=33", a_r0);
    end
    step();
    n_tests++;
    if (a_r1 !== 8'h44 || a_empty !== 1'b1) begin
      n_fail++; $display("FAIL frame_r1 got=%h/%b exp=44/1", a_r1, a_empty);
    end
  endtask

  task automatic test_overflow();
    flush_buf();
    align_tick();
    for (int i = 0; i < 16; i++) do_push(i % 4, i);
    n_tests++;
    if (a_full !== 1'b1 || a_lvl !== 5'd16 || a_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_full got=%b/%0d/%b exp=1/16/0", a_full, a_lvl, a_ovf);
    end
    do_push(1, 8'hEE);
    n_tests++;
    if (a_ovf !== 1'b1 || a_lvl !== 5'd16) begin
      n_fail++; $display("FAIL ovf_drop got=%b/%0d exp=1/16", a_ovf, a_lvl);
    end
    status_rd = 1'b1;
    do_push(2, 8'hEF);
    status_rd = 1'b0;
    n_tests++;
    if (a_ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set_wins got=%b exp=1", a_ovf);
    end
    status_rd = 1'b1; step(); status_rd = 1'b0;
    n_tests++;
    if (a_ovf !== 1'b0 || obs0 !== mexp(0)) begin
      n_fail++; $display("FAIL ovf_clear got=%h exp=%h", obs0, mexp(0));
    end
  endtask

  task automatic test_partial_drain();
    bit ok;
    flush_buf();
    align_tick();
    for (int i = 0; i < 6; i++) do_push($urandom_range(0, 3), $urandom_range(0, 255));
    ok = 0;
    for (int i = 0; i < 700; i++) begin
      step();
      n_tests++;
      if (obs0 !== mexp(0)) begin
        n_fail++; $display("FAIL part_wait got=%h exp=%h", obs0, mexp(0));
      end
      if (a_lvl == 5'd2) begin ok = 1; break; end
    end
    step(); step(); step();
    n_tests++;
    if (!ok || a_lvl !== 5'd2) begin
      n_fail++; $display("FAIL part_level got=%0d exp=2 ok=%0d", a_lvl, ok);
    end
    ok = 0;
    for (int i = 0; i < 700; i++) begin
      step();
      if (a_empty) begin ok = 1; break; end
    end
    n_tests++;
    if (!ok || obs0 !== mexp(0)) begin
      n_fail++; $display("FAIL part_second got=%h exp=%h", obs0, mexp(0));
    end
  endtask

  task automatic test_pending();
    flush_buf();
    for (int i = 0; i < 12; i++) begin
      do_push($urandom_range(0, 3), $urandom_range(0, 255));
      n_tests++;
      if (obs1 !== mexp(1)) begin
        n_fail++; $display("FAIL pend_push got=%h exp=%h", obs1, mexp(1));
      end
    end
    for (int i = 0; i < 40; i++) begin
      step();
      n_tests++;
      if (obs1 !== mexp(1)) begin
        n_fail++; $display("FAIL pend_drain got=%h exp=%h", obs1, mexp(1));
      end
    end
    n_tests++;
    if (b_empty !== 1'b1) begin
      n_fail++; $display("FAIL pend_empty got=%b exp=1", b_empty);
    end
  endtask

  task automatic test_mode_change();
    bit ok;
    logic [7:0] d [5];
    for (int pass = 0; pass < 2; pass++) begin
      flush_buf();
      align_tick();
      for (int i = 0; i < 5; i++) begin
        d[i] = 8'($urandom);
        do_push(i % 4, d[i]);
      end
      ok = 0;
      for (int i = 0; i < 700; i++) begin
        step();
        if (a_lvl == 5'd3) begin ok = 1; break; end
      end
      n_tests++;
      if (!ok || a_l0 !== d[0] || a_l1 !== d[1]) begin
        n_fail++;
        $display("FAIL mode_mid got=%h/%h exp=%h/%h", a_l0, a_l1, d[0], d[1]);
      end
      if (pass == 0) begin
        buf_mode = 1'b0; step();
        n_tests++;
        if (a_lvl !== 5'd0 || a_l0 !== d[0] || a_l1 !== d[1] ||
            obs0 !== mexp(0)) begin
          n_fail++; $display("FAIL mode_flush got=%h exp=%h", obs0, mexp(0));
        end
        step(); step();
        n_tests++;
        if (obs0 !== mexp(0) || a_empty !== 1'b1) begin
          n_fail++; $display("FAIL mode_hold got=%h exp=%h", obs0, mexp(0));
        end
        buf_mode = 1'b1;
      end else begin
        rst_n = 1'b0; step(); rst_n = 1'b1;
        n_tests++;
        if (obs0 !== 40'h2) begin
          n_fail++; $display("FAIL mode_reset got=%h exp=%h", obs0, 40'h2);
        end
        step();
      end
    end
  endtask

  task automatic test_rate();
    bit ok;
    int c0, c1, c2;
    flush_buf();
    rate_wr = 1'b1; rate_data = 8'h03; step(); rate_wr = 1'b0;
    c0 = cyc; c1 = 0; c2 = 0;
    do_push(0, 8'h5A);
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      if (a_empty) begin ok = 1; c1 = cyc; break; end
      step();
    end
`ifdef SD_RATE_PROG_EN
    n_tests++;
    if (!ok || c1 - c0 !== 129) begin
      n_fail++; $display("FAIL rate_restart got=%0d exp=129", c1 - c0);
    end
`endif
    do_push(0, 8'hA5);
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      if (a_empty) begin ok = 1; c2 = cyc; break; end
      step();
    end
    n_tests++;
    if (!ok || c2 - c1 !== EXP_P || a_l0 !== 8'hA5) begin
      n_fail++;
      $display("FAIL rate_period got=%0d exp=%0d l0=%h", c2 - c1, EXP_P, a_l0);
    end
    n_tests++;
    if (obs0 !== mexp(0) || obs1 !== mexp(1)) begin
      n_fail++; $display("FAIL rate_model got=%h exp=%h", obs0, mexp(0));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 399) != 0);
      en        = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 63) == 0) buf_mode = ~buf_mode;
      wr        = 1'($urandom_range(0, 1));
      wr_ch     = 2'($urandom);
      wr_data   = 8'($urandom);
      status_rd = ($urandom_range(0, 19) == 0);
      rate_wr   = ($urandom_range(0, 199) == 0);
      rate_data = 8'($urandom_range(0, 7));
      step();
      n_tests++;
      if (obs0 !== mexp(0)) begin
        n_fail++; $display("FAIL rand_a got=%h exp=%h", obs0, mexp(0));
      end
      n_tests++;
      if (obs1 !== mexp(1)) begin
        n_fail++; $display("FAIL rand_b got=%h exp=%h", obs1, mexp(1));
      end
    end
    rst_n = 1'b1; wr = 1'b0; status_rd = 1'b0; rate_wr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_direct();
    test_buffered_frame();
    test_overflow();
    test_partial_drain();
    test_pending();
    test_mode_change();
    test_rate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
